// File: rtl/obuf_tag_sequencer.sv
// Round-robin tag steering between the block controller and the per-bank obuf tag logic.
// Optional protocol checking is enabled by defining OBUF_TAG_SEQ_ERR_CHECK_EN.
module obuf_tag_sequencer #(
    parameter int unsigned NUM_TAGS = 2,
    parameter int unsigned TAG_W    = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                block_req,
    input  logic                block_reuse,
    input  logic                block_flush,
    output logic                block_ready,
    output logic [NUM_TAGS-1:0] tag_req,
    output logic [NUM_TAGS-1:0] tag_reuse,
    output logic [NUM_TAGS-1:0] tag_flush,
    input  logic [NUM_TAGS-1:0] tag_free,
    input  logic [NUM_TAGS-1:0] tag_ldmem_ready,
    input  logic [NUM_TAGS-1:0] tag_compute_ready,
    input  logic [NUM_TAGS-1:0] tag_stmem_ready,
    input  logic [NUM_TAGS-1:0] tag_next_compute,
    input  logic                ldmem_done,
    input  logic                compute_done,
    input  logic                stmem_done,
    output logic [NUM_TAGS-1:0] tag_ldmem_done,
    output logic [NUM_TAGS-1:0] tag_compute_done,
    output logic [NUM_TAGS-1:0] tag_stmem_done,
    output logic [TAG_W-1:0]    ldmem_tag,
    output logic [TAG_W-1:0]    compute_tag,
    output logic [TAG_W-1:0]    stmem_tag,
    output logic                ldmem_ready,
    output logic                compute_ready,
    output logic                stmem_ready,
    output logic [TAG_W:0]      outstanding,
    output logic                err
);

    localparam int unsigned CNT_W = TAG_W + 1;
    localparam logic [NUM_TAGS-1:0] ONE_HOT0 = NUM_TAGS'(1);

    logic [TAG_W-1:0] alloc_ptr_q,   alloc_ptr_d;
    logic [TAG_W-1:0] last_ptr_q,    last_ptr_d;
    logic             last_valid_q,  last_valid_d;
    logic [TAG_W-1:0] ldmem_ptr_q,   ldmem_ptr_d;
    logic [TAG_W-1:0] compute_ptr_q, compute_ptr_d;
    logic [TAG_W-1:0] stmem_ptr_q,   stmem_ptr_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;

    logic accept;
    logic retire;

    assign block_ready   = tag_free[alloc_ptr_q] && (outstanding_q < CNT_W'(NUM_TAGS));
    assign accept        = block_req && block_ready;
    assign retire        = stmem_done && (outstanding_q != '0);

    assign ldmem_tag     = ldmem_ptr_q;
    assign compute_tag   = compute_ptr_q;
    assign stmem_tag     = stmem_ptr_q;
    assign ldmem_ready   = tag_ldmem_ready[ldmem_ptr_q];
    assign compute_ready = tag_compute_ready[compute_ptr_q];
    assign stmem_ready   = tag_stmem_ready[stmem_ptr_q];
    assign outstanding   = outstanding_q;

    // Zero-latency one-hot steering; reuse/flush use the pre-update last_ptr.
    always_comb begin
        tag_req          = '0;
        tag_reuse        = '0;
        tag_flush        = '0;
        tag_ldmem_done   = '0;
        tag_compute_done = '0;
        tag_stmem_done   = '0;
        if (accept)                      tag_req          = ONE_HOT0 << alloc_ptr_q;
        if (block_reuse && last_valid_q) tag_reuse        = ONE_HOT0 << last_ptr_q;
        if (block_flush && last_valid_q) tag_flush        = ONE_HOT0 << last_ptr_q;
        if (ldmem_done)                  tag_ldmem_done   = ONE_HOT0 << ldmem_ptr_q;
        if (compute_done)                tag_compute_done = ONE_HOT0 << compute_ptr_q;
        if (stmem_done)                  tag_stmem_done   = ONE_HOT0 << stmem_ptr_q;
    end

    // Pointer and occupancy next-state; pointers wrap naturally at NUM_TAGS.
    always_comb begin
        alloc_ptr_d   = alloc_ptr_q;
        last_ptr_d    = last_ptr_q;
        last_valid_d  = last_valid_q;
        ldmem_ptr_d   = ldmem_ptr_q;
        compute_ptr_d = compute_ptr_q;
        stmem_ptr_d   = stmem_ptr_q;
        outstanding_d = outstanding_q;

        if (accept) begin
            last_ptr_d   = alloc_ptr_q;
            last_valid_d = 1'b1;
            alloc_ptr_d  = alloc_ptr_q + TAG_W'(1);
        end
        if (ldmem_done)                      ldmem_ptr_d   = ldmem_ptr_q + TAG_W'(1);
        if (tag_next_compute[compute_ptr_q]) compute_ptr_d = compute_ptr_q + TAG_W'(1);
        if (stmem_done)                      stmem_ptr_d   = stmem_ptr_q + TAG_W'(1);

        unique case ({accept, retire})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alloc_ptr_q   <= '0;
            last_ptr_q    <= '0;
            last_valid_q  <= 1'b0;
            ldmem_ptr_q   <= '0;
            compute_ptr_q <= '0;
            stmem_ptr_q   <= '0;
            outstanding_q <= '0;
        end else begin
            alloc_ptr_q   <= alloc_ptr_d;
            last_ptr_q    <= last_ptr_d;
            last_valid_q  <= last_valid_d;
            ldmem_ptr_q   <= ldmem_ptr_d;
            compute_ptr_q <= compute_ptr_d;
            stmem_ptr_q   <= stmem_ptr_d;
            outstanding_q <= outstanding_d;
        end
    end

`ifdef OBUF_TAG_SEQ_ERR_CHECK_EN
    logic err_q, err_d;

    // Sticky protocol violation flag; observation only, never masks decode.
    always_comb begin
        err_d = err_q
              | (ldmem_done   && !ldmem_ready)
              | (compute_done && !compute_ready)
              | (stmem_done   && !stmem_ready)
              | ((block_reuse || block_flush) && !last_valid_q)
              | (block_req    && !block_ready);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/obuf_tag_sequencer.md
Name: obuf_tag_sequencer

Overview:
- Sits directly upstream of the NUM_TAGS obuf tag-logic instances, one per output-buffer bank.
- Takes a single block-level request/reuse/flush stream from the controller and steers each event to the correct tag instance.
- Keeps one round-robin tag pointer each for allocation, load-memory, compute and store-memory.
- Fans the stage done pulses back to the tag that owns the stage, and gives each stage its current tag index and ready flag.

Parameters:
NUM_TAGS, 2, number of obuf banks / tag-logic instances; power of two, 2..8
TAG_W, 1, index width, equals log2(NUM_TAGS)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
block_req  in  1  controller requests a fresh tag
block_reuse  in  1  controller reuses the most recently allocated tag
block_flush  in  1  controller marks the most recently allocated tag final
block_ready  out  1  tag at alloc_ptr is free; block_req accepted only when high
tag_req  out  NUM_TAGS  one-hot request to the tag instances
tag_reuse  out  NUM_TAGS  one-hot reuse to the tag instances
tag_flush  out  NUM_TAGS  one-hot flush to the tag instances
tag_free  in  NUM_TAGS  per-tag free/ready status
tag_ldmem_ready  in  NUM_TAGS  per-tag load-ready status
tag_compute_ready  in  NUM_TAGS  per-tag compute-ready status
tag_stmem_ready  in  NUM_TAGS  per-tag store-ready status
tag_next_compute  in  NUM_TAGS  per-tag "leaving compute" pulse
ldmem_done  in  1  load stage finished its tag
compute_done  in  1  compute stage finished one pass
stmem_done  in  1  store stage finished its tag
tag_ldmem_done  out  NUM_TAGS  one-hot done to the tag instances
tag_compute_done  out  NUM_TAGS  one-hot done to the tag instances
tag_stmem_done  out  NUM_TAGS  one-hot done to the tag instances
ldmem_tag  out  TAG_W  current load tag index
compute_tag  out  TAG_W  current compute tag index
stmem_tag  out  TAG_W  current store tag index
ldmem_ready  out  1  tag_ldmem_ready[ldmem_tag]
compute_ready  out  1  tag_compute_ready[compute_tag]
stmem_ready  out  1  tag_stmem_ready[stmem_tag]
outstanding  out  TAG_W+1  tags currently allocated and not yet freed
err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert)
  - All pointers, outstanding, last_valid and err go to 0.
  - Every one-hot output reads 0; ldmem_tag, compute_tag and stmem_tag read 0.
  - Reset mid-operation discards all state; the tag instances are reset by the same system.
- All one-hot outputs are combinational, zero latency, decoded from the current pointer. Pointers and counters update on the next rising edge.
- Allocation
  - Accept when block_req && block_ready.
  - tag_req[alloc_ptr]=1; last_ptr<=alloc_ptr; last_valid<=1; alloc_ptr<=alloc_ptr+1 mod NUM_TAGS; outstanding+1.
  - block_req while block_ready=0: no output, no state change.
- Reuse: block_reuse && last_valid -> tag_reuse[last_ptr]=1. Without last_valid the event is ignored.
- Flush
  - block_flush && last_valid -> tag_flush[last_ptr]=1.
  - If block_req is accepted in the same cycle, the flush still targets the old last_ptr; the flush decode uses the pre-update last_ptr.
- Load stage: ldmem_done -> tag_ldmem_done[ldmem_ptr]=1; ldmem_ptr+1.
- Compute stage
  - compute_done -> tag_compute_done[compute_ptr]=1.
  - compute_ptr advances only on tag_next_compute[compute_ptr]. Reuse passes therefore stay on the same tag.
- Store stage: stmem_done -> tag_stmem_done[stmem_ptr]=1; stmem_ptr+1; outstanding-1.
- Simultaneous accepted block_req and stmem_done: outstanding unchanged.
- block_ready = tag_free[alloc_ptr] && outstanding < NUM_TAGS.
- Wrap-around: every pointer wraps from NUM_TAGS-1 to 0.
- Done pulses are single-cycle pass-through. A multi-cycle done level advances the pointer once per cycle; the controller must pulse.

Optional Feature:
OBUF_TAG_SEQ_ERR_CHECK_EN
- Defined: err sets and stays set until reset when any of these occur:
  - ldmem_done while ldmem_ready=0
  - compute_done while compute_ready=0
  - stmem_done while stmem_ready=0
  - block_reuse or block_flush while last_valid=0
  - block_req while block_ready=0
- Error events are still decoded exactly as in Behaviour; the check adds no masking.
- Undefined: err tied to 0, no checking logic.

Test Plan:
- Reset, then NUM_TAGS=2 with tag_free=2'b11 and one block_req -> tag_req=2'b01 that cycle; next cycle alloc_ptr=1, outstanding=1.
- Two block_req accepted, third with tag_free[0]=0 -> third ignored, block_ready=0, outstanding=2.
- Alloc tag 0, two block_reuse, then block_flush -> tag_reuse=2'b01 twice, tag_flush=2'b01. Two compute_done keep compute_tag=0; tag_next_compute=2'b01 -> compute_tag=1.
- Full cycle over both tags: ldmem_done ×2, compute passes, stmem_done ×2 -> each stage pointer returns to 0 and outstanding=0.
- Same-cycle block_req and stmem_done with outstanding=1 -> outstanding stays 1, tag_req and tag_stmem_done both pulse.
- With OBUF_TAG_SEQ_ERR_CHECK_EN defined, block_reuse after reset -> err=1 next cycle and held; assert reset_n low -> err=0 immediately.
